// File: rtl/ex_mult_iter_unit.sv
// Iterative shift-add multiplier for the EX stage: stalls upstream while it works and
// presents the low DATA_W product bits for one cycle. Optional MULT_EARLY_TERM_EN ends early once the multiplier is exhausted.
module ex_mult_iter_unit #(
  parameter int DATA_W         = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              busy_o
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_r;
  logic [DATA_W-1:0]   mcand_r;
  logic [DATA_W-1:0]   mplier_r;
  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   result_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                done_r;
  logic                busy_r;

  logic [DATA_W-1:0]   mplier_next_s;
  logic [DATA_W-1:0]   acc_next_s;
  logic                last_s;

  assign mplier_next_s = mplier_r >> BITS_PER_CYCLE;
  assign acc_next_s    = acc_r + (mcand_r * DATA_W'(mplier_r[BITS_PER_CYCLE-1:0]));

`ifdef MULT_EARLY_TERM_EN
  assign last_s = (cnt_r == {CNT_W{1'b0}}) || (mplier_next_s == {DATA_W{1'b0}});
`else
  assign last_s = (cnt_r == {CNT_W{1'b0}});
`endif

  // Flush or reset in the DONE cycle must hide the result from EX/MEM, so done/result gate late.
  assign stall_o  = ~rst & ~flush_i &
                    (((state_r == IDLE) & start_i) | (state_r == BUSY));
  assign done_o   = done_r & ~flush_i & ~rst;
  assign result_o = done_o ? acc_r : result_r;
  assign busy_o   = busy_r;

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i && !flush_i) begin
            mcand_r  <= op_a_i;
            mplier_r <= op_b_i;
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= CNT_W'(N - 1);
            busy_r   <= 1'b1;
`ifdef MULT_EARLY_TERM_EN
            if (op_b_i == {DATA_W{1'b0}}) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= BUSY;
              done_r  <= 1'b0;
            end
`else
            state_r <= BUSY;
            done_r  <= 1'b0;
`endif
          end else begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << BITS_PER_CYCLE;
            mplier_r <= mplier_next_s;
            if (last_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              cnt_r   <= cnt_r - CNT_W'(1);
              done_r  <= 1'b0;
            end
          end
        end
        DONE: begin
          // start_i is ignored here: ID/EX still holds the MUL that just finished.
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          if (!flush_i) begin
            result_r <= acc_r;
          end else begin
            result_r <= result_r;
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
